alu4_serial16: RTL and testbench

Nibble-serial operand sequencer that sits on both sides of the 4-bit `alu`. It accepts a wide operand pair and op code through a valid/ready handshake, then feeds the `alu` one nibble per cycle, least-significant nibble first, chaining `cout` back into `cin`. It assembles the result nibbles into a wide word and presents it downstream through a second valid/ready handshake. It is the multi-precision front end for the 4-bit datapath.

---
 rtl/alu4_pkg.sv | 17 +
 rtl/alu4_serial16.sv | 131 +++++++++++++
 tb/tb_alu4_serial16.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared types and constants for the nibble-serial ALU sequencer
package alu4_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu4_serial16.sv
// rtl/alu4_serial16.sv - nibble-serial operand sequencer around a 4-bit alu (optional zero flag: ALU4_SER_ZERO_FLAG_EN)
module alu4_serial16 import alu4_pkg::*; #(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W*NIBBLES-1:0] in_a,
    input  logic [NIB_W*NIBBLES-1:0] in_b,
    input  logic [1:0]               in_op,
    input  logic                     in_cin,
    output logic [NIB_W-1:0]         alu_a,
    output logic [NIB_W-1:0]         alu_b,
    output logic [1:0]               alu_op,
    output logic                     alu_cin,
    input  logic [NIB_W-1:0]         alu_res,
    input  logic                     alu_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] out_res,
    output logic                     out_cout,
    output logic                     out_zero
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    ser_state_t      state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    res;
    logic [W-1:0]    res_next;
    logic [1:0]      op_r;
    logic            carry;
    logic            valid_r;
    logic            accept;

    // Ready when idle, or when the held result is being taken this cycle
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Drive the current operand nibbles to the alu only while running
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = '0;
        alu_cin = 1'b0;
        if (state == RUN) begin
            alu_a   = a_r[NIB_W*idx +: NIB_W];
            alu_b   = b_r[NIB_W*idx +: NIB_W];
            alu_op  = op_r;
            alu_cin = carry;
        end
    end

    // Result word with the current alu nibble merged in at idx
    always_comb begin
        res_next = res;
        res_next[NIB_W*idx +: NIB_W] = alu_res;
    end

    // Sequencer: accept, step one nibble per cycle, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            carry   <= 1'b0;
            res     <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    res   <= res_next;
                    carry <= alu_cout;
                    if (idx == LAST) begin
                        idx     <= '0;
                        state   <= DONE;
                        valid_r <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    if ((state == DONE) && out_ready) begin
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end
                    // A request arriving with the handoff skips IDLE entirely
                    if (accept) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        op_r  <= in_op;
                        carry <= in_cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
            endcase
        end
    end

`ifdef ALU4_SER_ZERO_FLAG_EN
    logic zero_r;

    // Zero flag captured from the completed word as the block enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_r <= 1'b0;
        end else if ((state == RUN) && (idx == LAST)) begin
            zero_r <= (res_next == '0);
        end
    end

    assign out_zero = zero_r;
`else
    assign out_zero = 1'b0;
`endif

    assign out_valid = valid_r;
    assign out_res   = res;
    assign out_cout  = carry;

endmodule

// File: tb/tb_alu4_serial16.sv
// tb/tb_alu4_serial16.sv - self-checking bench for alu4_serial16 with a behavioural 4-bit alu
module tb_alu4_serial16;
    import alu4_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         in_cin;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [1:0]   alu_op;
    logic         alu_cin;
    logic [3:0]   alu_res;
    logic         alu_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_cout;
    logic         out_zero;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_zero;

    always #5 clk = ~clk;

    alu4_serial16 #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_cout(out_cout), .out_zero(out_zero)
    );

    // Behavioural 4-bit alu: subtract is a + ~b + cin, logic ops give no carry
    always_comb begin
        logic [4:0] s;
        s = 5'd0;
        case (alu_op)
            OP_ADD: s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
            OP_SUB: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
            OP_AND: s = {1'b0, alu_a & alu_b};
            default: s = {1'b0, alu_a | alu_b};
        endcase
        alu_res  = s[3:0];
        alu_cout = s[4];
    end

    // Wide reference: the whole W-bit operation in one step
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic cin);
        logic [W-1:0] nb;
        nb = ~b;
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            OP_SUB:  return {1'b0, a} + {1'b0, nb} + (W+1)'(cin);
            OP_AND:  return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Carry entering nibble k, from the sum of the operands' low 4k bits
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op, input logic cin, input int k);
        longint unsigned mask, sum, bb;
        if (k == 0) return cin;
        if (op == OP_AND || op == OP_OR) return 1'b0;
        bb   = (op == OP_SUB) ? longint'(~b) : longint'(b);
        mask = (64'd1 << (4 * k)) - 64'd1;
        sum  = (longint'(a) & mask) + (bb & mask) + longint'(cin);
        return sum[4*k];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at the current low phase and let it be accepted on the next edge
    task automatic accept_req(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] op, input logic cin, input bit b2b);
        in_a = a; in_b = b; in_op = op; in_cin = cin;
        in_valid = 1'b1;
        if (b2b) out_ready = 1'b1;
        #1 chk("in_ready_at_accept", 64'(in_ready), 64'd1);
        {exp_cout, exp_res} = model(a, b, op, cin);
`ifdef ALU4_SER_ZERO_FLAG_EN
        exp_zero = (exp_res == '0);
`else
        exp_zero = 1'b0;
`endif
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Observe nibbles 0..cnt-1 on the alu ports, one per cycle
    task automatic run_nibbles(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op, input logic cin, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            @(negedge clk);
            chk($sformatf("alu_a[%0d]", k), 64'(alu_a), 64'(a[4*k +: 4]));
            chk($sformatf("alu_b[%0d]", k), 64'(alu_b), 64'(b[4*k +: 4]));
            chk($sformatf("alu_op[%0d]", k), 64'(alu_op), 64'(op));
            chk($sformatf("alu_cin[%0d]", k), 64'(alu_cin), 64'(carry_into(a, b, op, cin, k)));
            chk($sformatf("run_valid[%0d]", k), 64'(out_valid), 64'd0);
            chk($sformatf("run_in_ready[%0d]", k), 64'(in_ready), 64'd0);
        end
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_res"}, 64'(out_res), 64'(exp_res));
        chk({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
        chk({tag, "_zero"}, 64'(out_zero), 64'(exp_zero));
        chk({tag, "_alu_idle"}, 64'({alu_a, alu_b, alu_op, alu_cin}), 64'd0);
    endtask

    task automatic full_req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, input logic cin, input bit b2b);
        accept_req(a, b, op, cin, b2b);
        run_nibbles(a, b, op, cin, N);
        check_done(tag);
    endtask

    // Hold the result for some cycles, then hand it off
    task automatic release_res(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_res", 64'(out_res), 64'(exp_res));
            chk("hold_cout", 64'(out_cout), 64'(exp_cout));
            chk("hold_zero", 64'(out_zero), 64'(exp_zero));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1 chk("handoff_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("after_handoff_valid", 64'(out_valid), 64'd0);
        chk("after_handoff_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        logic         rcin;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res", 64'(out_res), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_alu", 64'({alu_a, alu_b, alu_op, alu_cin}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        full_req("add_nc", 16'h1234, 16'h0FFF, OP_ADD, 1'b0, 1'b0);
        chk("add_nc_literal", 64'(out_res), 64'h2233);
        release_res(0);

        full_req("add_ripple", 16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
        chk("add_ripple_literal", 64'({out_cout, out_res}), 64'h1_0000);
        release_res(5);

        full_req("or_pass", 16'hA5A5, 16'h0F0F, OP_OR, 1'b0, 1'b0);
        chk("or_literal", 64'(out_res), 64'hAFAF);
        full_req("b2b_sub", 16'h1000, 16'h0001, OP_SUB, 1'b1, 1'b1);
        release_res(1);

        // Reset pulsed while nibble 2 is on the alu
        accept_req(16'h5555, 16'h3333, OP_ADD, 1'b1, 1'b0);
        run_nibbles(16'h5555, 16'h3333, OP_ADD, 1'b1, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_alu", 64'({alu_a, alu_b, alu_op, alu_cin}), 64'd0);
        chk("mid_rst_res", 64'(out_res), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_alu", 64'({alu_a, alu_b, alu_op, alu_cin}), 64'd0);
        full_req("post_rst_add", 16'h0001, 16'h0001, OP_ADD, 1'b0, 1'b0);
        chk("post_rst_literal", 64'(out_res), 64'h0002);
        release_res(0);

        for (int t = 0; t < 24; t++) begin
            ra   = W'($urandom);
            rb   = (t % 6 == 0) ? ~ra : W'($urandom);
            rop  = 2'($urandom_range(0, 3));
            rcin = 1'($urandom);
            if (t % 8 == 7) rb = W'(0) - ra;
            full_req("rand", ra, rb, rop, rcin, (t % 3 == 1));
            if (t % 3 != 0) release_res($urandom_range(0, 3));
        end
        release_res(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
